// File: rtl/mem_port_arbiter_pkg.sv
// riscv_mem_pkg: shared access-length, FSM state and owner types for the memory port arbiter
package riscv_mem_pkg;
  typedef enum logic [1:0] {LEN_NONE = 2'b00, LEN_BYTE = 2'b01, LEN_HALF = 2'b10, LEN_WORD = 2'b11} len_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory handshake bundle; master = arbiter, slave = requesters plus memory
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [1:0]        d_len;
  logic              d_signed;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic              mem_signed;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  i_req, i_addr, d_req, d_addr, d_we, d_len, d_signed, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_addr, mem_we, mem_len, mem_signed, mem_wdata
  );
  modport slave (
    output i_req, i_addr, d_req, d_addr, d_we, d_len, d_signed, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_addr, mem_we, mem_len, mem_signed, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_align_chk.sv
// mem_align_chk: flags an illegal length or a misaligned address for one memory access
module mem_align_chk
  import riscv_mem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] len,
  output logic       bad
);
  assign bad = (len == LEN_NONE) || (len == LEN_HALF && addr_lo[0]) || (len == LEN_WORD && addr_lo != 2'b00);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, D priority; ARB_STARVE_GUARD_EN adds the fetch starve guard
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input logic                SYS_clk,
  input logic                SYS_reset_n,
  mem_port_arbiter_if.master bus
);
  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic              go, pick_d, i_grant, d_grant, bad, fin;
  logic [1:0]        sel_lo, sel_len;
  assign go      = SYS_reset_n && state_q == IDLE && (bus.i_req || bus.d_req);
  assign d_grant = go && pick_d;
  assign i_grant = go && !pick_d;
  assign sel_lo  = pick_d ? bus.d_addr[1:0] : bus.i_addr[1:0];
  assign sel_len = pick_d ? bus.d_len : LEN_WORD;
  mem_align_chk u_align_chk (
    .addr_lo (sel_lo),
    .len     (sel_len),
    .bad     (bad)
  );
`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign pick_d = bus.d_req && !(bus.i_req && cnt_q == CNT_W'(STARVE_LIMIT));
  assign cnt_d  = (!bus.i_req || i_grant) ? '0 : d_grant ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign pick_d = bus.d_req;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        owner_d = pick_d ? OWN_D : OWN_I;
        addr_d  = pick_d ? bus.d_addr : bus.i_addr;
        we_d    = pick_d && bus.d_we;
        len_d   = sel_len;
        sgn_d   = pick_d && bus.d_signed;
        wdata_d = pick_d ? bus.d_wdata : '0;
        state_d = bad ? ERR : REQ;
      end
      REQ: state_d = bus.mem_gnt ? RESP : REQ;
      RESP: if (bus.mem_rvalid) begin
        resp_d  = 1'b1;
        rdata_d = we_q ? '0 : bus.mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= 2'b00;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      len_q   <= len_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end
  assign fin            = resp_q || state_q == ERR;
  assign bus.i_gnt      = i_grant;
  assign bus.d_gnt      = d_grant;
  assign bus.i_rvalid   = fin && owner_q == OWN_I;
  assign bus.d_rvalid   = fin && owner_q == OWN_D;
  assign bus.i_err      = state_q == ERR && owner_q == OWN_I;
  assign bus.d_err      = state_q == ERR && owner_q == OWN_D;
  assign bus.i_rdata    = (resp_q && owner_q == OWN_I) ? rdata_q : '0;
  assign bus.d_rdata    = (resp_q && owner_q == OWN_D) ? rdata_q : '0;
  assign bus.mem_req    = state_q == REQ;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_len    = len_q;
  assign bus.mem_signed = sgn_q;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions plus arbitration, stall, reset and starvation sequences
module tb_mem_port_arbiter;
  logic SYS_clk;
  logic SYS_reset_n;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset_n (SYS_reset_n),
    .bus         (bus)
  );
  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;
  int n_chk = 0;
  int n_err = 0;
  logic fire = 1'b0;
  logic rv_hold = 1'b0;
  logic rv_inject = 1'b0;
  int stall = 0;
  logic [31:0] mem_word = '0;
  always @(negedge SYS_clk) fire = bus.mem_req && bus.mem_gnt;
  always @(posedge SYS_clk) begin
    #2;
    bus.mem_rvalid = rv_hold ? rv_inject : fire;
    bus.mem_rdata = mem_word;
    if (bus.mem_req && stall > 0) begin
      bus.mem_gnt = 1'b0;
      stall--;
    end else bus.mem_gnt = bus.mem_req;
  end
  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge SYS_clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int rv_at;
    int mreq_n;
    logic [31:0] rd;
    logic er;
    logic other;
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.d_req = v.is_d;
    bus.i_req = !v.is_d;
    bus.d_addr = v.addr;
    bus.i_addr = v.addr;
    bus.d_we = v.we;
    bus.d_len = v.len;
    bus.d_signed = v.sgn;
    bus.d_wdata = v.wdata;
    mem_word = v.mem_data;
    @(negedge SYS_clk);
    chk({tag, "_gnt"}, {bus.d_gnt, bus.i_gnt}, v.is_d ? 2'b10 : 2'b01);
    rv_at = -1;
    mreq_n = 0;
    rd = '0;
    er = 1'b0;
    other = 1'b0;
    for (int c = 1; c < 10 && rv_at < 0; c++) begin
      cyc();
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
      @(negedge SYS_clk);
      if (bus.mem_req) begin
        mreq_n++;
        chk({tag, "_mem_fields"}, {bus.mem_addr, bus.mem_we, bus.mem_len, bus.mem_signed},
            {v.addr, v.is_d && v.we, v.is_d ? v.len : 2'b11, v.is_d && v.sgn});
        chk({tag, "_mem_wdata"}, bus.mem_wdata, (v.is_d && v.we) ? v.wdata : 32'h0);
      end
      if (bus.d_rvalid || bus.i_rvalid) begin
        rv_at = c;
        other = v.is_d ? bus.i_rvalid : bus.d_rvalid;
        rd = v.is_d ? bus.d_rdata : bus.i_rdata;
        er = v.is_d ? bus.d_err : bus.i_err;
      end
    end
    chk({tag, "_latency"}, rv_at, v.exp_err ? 1 : 3);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_err"}, {other, er}, {1'b0, v.exp_err});
    chk({tag, "_mem_req_cycles"}, mreq_n, v.exp_err ? 0 : 1);
    cyc();
  endtask
  logic order[16];
  int n_gnt;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 2'b11, 1'b0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h200, 1'b0, 2'b11, 1'b0, 32'h0,        32'h00000013, 32'h00000013, 1'b0};
    vecs[2] = '{1'b1, 32'h104, 1'b1, 2'b11, 1'b0, 32'h12345678, 32'h0000AAAA, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 32'h101, 1'b0, 2'b10, 1'b0, 32'h0,        32'h55555555, 32'h0,        1'b1};
    vecs[4] = '{1'b1, 32'h100, 1'b0, 2'b00, 1'b0, 32'h0,        32'h55555555, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 32'h202, 1'b0, 2'b11, 1'b0, 32'h0,        32'h55555555, 32'h0,        1'b1};
    vecs[6] = '{1'b1, 32'h103, 1'b0, 2'b01, 1'b1, 32'h0,        32'hFFFFFF80, 32'hFFFFFF80, 1'b0};
    vecs[7] = '{1'b1, 32'h102, 1'b0, 2'b10, 1'b0, 32'h0,        32'h0000BEEF, 32'h0000BEEF, 1'b0};
    vecs[8] = '{1'b1, 32'h106, 1'b0, 2'b11, 1'b0, 32'h0,        32'h55555555, 32'h0,        1'b1};
    SYS_reset_n = 1'b0;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_addr = '0;
    bus.d_we = 1'b0;
    bus.d_len = 2'b00;
    bus.d_signed = 1'b0;
    bus.d_wdata = '0;
    repeat (2) @(posedge SYS_clk);
    @(negedge SYS_clk);
    chk("reset_outputs", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.mem_req,
        bus.mem_we, bus.mem_len, bus.mem_signed}, '0);
    chk("reset_data", {bus.mem_addr, bus.mem_wdata}, '0);
    cyc();
    SYS_reset_n = 1'b1;
    cyc();
    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    bus.d_addr = 32'h400;
    bus.d_we = 1'b0;
    bus.d_len = 2'b11;
    bus.d_signed = 1'b0;
    bus.i_addr = 32'h500;
    mem_word = 32'h11112222;
    @(negedge SYS_clk);
    chk("both_c0_gnt", {bus.d_gnt, bus.i_gnt}, 2'b10);
    cyc();
    bus.d_req = 1'b0;
    @(negedge SYS_clk);
    chk("both_c1_no_gnt", {bus.d_gnt, bus.i_gnt, bus.mem_req, bus.mem_addr}, {3'b001, 32'h400});
    cyc();
    @(negedge SYS_clk);
    cyc();
    @(negedge SYS_clk);
    chk("both_c3_rvalid_and_i_gnt", {bus.d_rvalid, bus.i_gnt, bus.d_gnt, bus.d_rdata}, {3'b110, 32'h11112222});
    cyc();
    bus.i_req = 1'b0;
    repeat (2) cyc();
    @(negedge SYS_clk);
    chk("both_c6_i_rvalid", {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.i_rdata}, {3'b100, 32'h11112222});
    cyc();
    stall = 5;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h300;
    bus.d_we = 1'b1;
    bus.d_wdata = 32'hCAFEF00D;
    @(negedge SYS_clk);
    chk("stall_gnt", bus.d_gnt, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      bus.d_req = 1'b0;
      @(negedge SYS_clk);
      chk($sformatf("stall_c%0d_hold", c), {bus.mem_req, bus.mem_gnt, bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {4'b1001, 32'h300, 32'hCAFEF00D});
    end
    cyc();
    @(negedge SYS_clk);
    chk("stall_c6_accept", {bus.mem_req, bus.mem_gnt}, 2'b11);
    repeat (2) cyc();
    @(negedge SYS_clk);
    chk("stall_c8_store_done", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {2'b10, 32'h0});
    cyc();
    rv_hold = 1'b1;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h600;
    bus.d_we = 1'b0;
    mem_word = 32'h77778888;
    @(negedge SYS_clk);
    chk("rst_mid_gnt", bus.d_gnt, 1'b1);
    cyc();
    bus.d_req = 1'b0;
    cyc();
    SYS_reset_n = 1'b0;
    @(negedge SYS_clk);
    chk("rst_mid_outputs", {bus.mem_req, bus.d_rvalid, bus.i_rvalid, bus.d_err, bus.i_err, bus.mem_addr}, '0);
    cyc();
    SYS_reset_n = 1'b1;
    rv_inject = 1'b1;
    cyc();
    rv_inject = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge SYS_clk);
      chk($sformatf("rst_drop_c%0d", c), {bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.mem_req}, '0);
      cyc();
    end
    rv_hold = 1'b0;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    bus.d_addr = 32'h700;
    bus.i_addr = 32'h800;
    n_gnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge SYS_clk);
      if ((bus.d_gnt || bus.i_gnt) && n_gnt < 16) begin
        order[n_gnt] = bus.d_gnt;
        n_gnt++;
      end
      cyc();
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_grants", n_gnt, 10);
    for (int k = 0; k < 6; k++) chk($sformatf("starve_order%0d", k), order[k], k != 4);
`else
    chk("starve_grants", n_gnt, 10);
    for (int k = 0; k < 10; k++) chk($sformatf("strict_order%0d", k), order[k], 1'b1);
`endif
    repeat (6) cyc();
    @(negedge SYS_clk);
    chk("final_idle", {bus.mem_req, bus.d_rvalid, bus.i_rvalid}, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
